noc_pkt_rr_arbiter: RTL and testbench

//  Parametrised N-input round-robin packet arbiter for one NoC router output port.

---
 rtl/noc_pkt_rr_arbiter_if.sv | 27 ++
 rtl/noc_pkt_rr_arbiter.sv | 132 +++++++++++++
 tb/tb_noc_pkt_rr_arbiter.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/noc_pkt_rr_arbiter_if.sv
// Request/flit handshake and grant bundle between NoC input ports and one output-port arbiter.
// master drives requests and flit handshake; slave (the arbiter) drives the grant.
interface noc_pkt_rr_arbiter_if #(
    parameter int N_PORTS = 5,
    parameter int IDX_W   = 3
);
    logic [N_PORTS-1:0] req_i;
    logic [N_PORTS-1:0] mask_i;
    logic [N_PORTS-1:0] prio_i;
    logic               flit_valid_i;
    logic               flit_ready_i;
    logic               tail_i;
    logic [IDX_W-1:0]   grant_idx_o;
    logic [N_PORTS-1:0] grant_vec_o;
    logic               grant_valid_o;
    logic               timeout_o;

    modport master (
        output req_i, mask_i, prio_i, flit_valid_i, flit_ready_i, tail_i,
        input  grant_idx_o, grant_vec_o, grant_valid_o, timeout_o
    );

    modport slave (
        input  req_i, mask_i, prio_i, flit_valid_i, flit_ready_i, tail_i,
        output grant_idx_o, grant_vec_o, grant_valid_o, timeout_o
    );
endinterface

// File: rtl/noc_pkt_rr_arbiter.sv
// Round-robin packet arbiter for one NoC output port: grants one input for a whole
// packet, released by flit count, tail flit or stall watchdog.
//
// state | meaning
// IDLE  | no grant; arbitrate eligible requests each cycle
// LOCK  | grant held for the current packet; requests ignored
module noc_pkt_rr_arbiter #(
    parameter int N_PORTS   = 5,
    parameter int IDX_W     = 3,
    parameter int PKT_MODE  = 0,
    parameter int MAX_FLITS = 5,
    parameter int TIMEOUT   = 0
) (
    input logic              clk,
    input logic              rst,
    noc_pkt_rr_arbiter_if.slave arb
);

    typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} state_t;

    localparam bit          WD_EN    = (TIMEOUT != 0);
    localparam logic [15:0] WD_LAST  = (TIMEOUT == 0) ? 16'd0 : 16'(TIMEOUT - 1);
    localparam logic [7:0]  CNT_LAST = 8'(MAX_FLITS - 1);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [N_PORTS-1:0] vec_q, vec_d;
    logic [7:0]         flit_cnt_q, flit_cnt_d;
    logic [15:0]        stall_cnt_q, stall_cnt_d;
    logic               timeout_q, timeout_d;

    logic [N_PORTS-1:0] elig, elig_hi, arb_set;
    logic               win_found;
    logic [IDX_W-1:0]   win_idx;
    logic               xfer, pkt_done, wd_fire;

    assign elig     = arb.req_i & ~arb.mask_i;
    assign elig_hi  = elig & arb.prio_i;
    assign arb_set  = (elig_hi != '0) ? elig_hi : elig;
    assign xfer     = arb.flit_valid_i & arb.flit_ready_i;
    assign pkt_done = (PKT_MODE == 0) ? (flit_cnt_q == CNT_LAST) : arb.tail_i;
    assign wd_fire  = WD_EN && !xfer && (stall_cnt_q == WD_LAST);

    // Ascending search from rr_ptr with wrap; first set bit wins.
    always_comb begin
        int j;
        j         = 0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            j = int'(rr_ptr_q) + i;
            if (j >= N_PORTS) j = j - N_PORTS;
            if (!win_found && arb_set[j]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(j);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        idx_d       = idx_q;
        vec_d       = vec_q;
        flit_cnt_d  = flit_cnt_q;
        stall_cnt_d = stall_cnt_q;
        timeout_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d     = LOCK;
                    idx_d       = win_idx;
                    vec_d       = N_PORTS'(1) << win_idx;
                    rr_ptr_d    = (win_idx == IDX_W'(N_PORTS - 1)) ? '0 : win_idx + 1'b1;
                    flit_cnt_d  = '0;
                    stall_cnt_d = '0;
                end
            end
            LOCK: begin
                if (xfer) begin
                    flit_cnt_d  = (flit_cnt_q == 8'hFF) ? flit_cnt_q : flit_cnt_q + 8'd1;
                    stall_cnt_d = '0;
                    if (pkt_done) begin
                        state_d = IDLE;
                        idx_d   = '1;
                        vec_d   = '0;
                    end
                end else begin
                    stall_cnt_d = (stall_cnt_q == 16'hFFFF) ? stall_cnt_q : stall_cnt_q + 16'd1;
                    if (wd_fire) begin
                        state_d   = IDLE;
                        idx_d     = '1;
                        vec_d     = '0;
                        timeout_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '1;
                vec_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            idx_q       <= '1;
            vec_q       <= '0;
            flit_cnt_q  <= '0;
            stall_cnt_q <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            idx_q       <= idx_d;
            vec_q       <= vec_d;
            flit_cnt_q  <= flit_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            timeout_q   <= timeout_d;
        end
    end

    assign arb.grant_idx_o   = idx_q;
    assign arb.grant_vec_o   = vec_q;
    assign arb.grant_valid_o = (state_q == LOCK);
    assign arb.timeout_o     = timeout_q;

endmodule

// File: tb/tb_noc_pkt_rr_arbiter.sv
// Directed bench: u0 is fixed-length (5 flits) with a 4-cycle watchdog, u1 is tail-released
// with the watchdog disabled; both see the same stimulus.
module tb_noc_pkt_rr_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [4:0] req = '0, mask = '0, prio = '0;
    logic valid = 1'b0, ready = 1'b0, tail = 1'b0;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    noc_pkt_rr_arbiter_if #(.N_PORTS(5), .IDX_W(3)) if0 ();
    noc_pkt_rr_arbiter_if #(.N_PORTS(5), .IDX_W(3)) if1 ();

    assign if0.req_i = req;  assign if0.mask_i = mask;  assign if0.prio_i = prio;
    assign if0.flit_valid_i = valid;  assign if0.flit_ready_i = ready;  assign if0.tail_i = tail;
    assign if1.req_i = req;  assign if1.mask_i = mask;  assign if1.prio_i = prio;
    assign if1.flit_valid_i = valid;  assign if1.flit_ready_i = ready;  assign if1.tail_i = tail;

    noc_pkt_rr_arbiter #(.N_PORTS(5), .IDX_W(3), .PKT_MODE(0), .MAX_FLITS(5), .TIMEOUT(4))
        u0 (.clk(clk), .rst(rst), .arb(if0));
    noc_pkt_rr_arbiter #(.N_PORTS(5), .IDX_W(3), .PKT_MODE(1), .MAX_FLITS(5), .TIMEOUT(0))
        u1 (.clk(clk), .rst(rst), .arb(if1));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0; mask = '0; prio = '0; valid = 1'b0; ready = 1'b0; tail = 1'b0;
        ticks(2);
        rst = 1'b0;
    endtask

    task automatic chk_u0_idle(input string tag);
        chk({tag, "_idx"},   32'(if0.grant_idx_o),   32'd7);
        chk({tag, "_vec"},   32'(if0.grant_vec_o),   32'd0);
        chk({tag, "_valid"}, 32'(if0.grant_valid_o), 32'd0);
    endtask

    initial begin
        // reset state
        do_reset();
        chk_u0_idle("rst");
        chk("rst_to", 32'(if0.timeout_o), 32'd0);
        chk("rst_u1_idx", 32'(if1.grant_idx_o), 32'd7);

        // 1: single request, fixed-length release
        req = 5'b00100;
        tick();
        chk("t1_idx", 32'(if0.grant_idx_o), 32'd2);
        chk("t1_vec", 32'(if0.grant_vec_o), 32'b00100);
        chk("t1_valid", 32'(if0.grant_valid_o), 32'd1);
        req = '0; valid = 1'b1; ready = 1'b1;
        ticks(4);
        chk("t1_after4", 32'(if0.grant_idx_o), 32'd2);
        tick();
        chk_u0_idle("t1_rel");
        chk("t1_u1_hold", 32'(if1.grant_valid_o), 32'd1);
        valid = 1'b0; ready = 1'b0;

        // 2: fairness with all requesting, transfers held on
        do_reset();
        req = 5'b11111; valid = 1'b1; ready = 1'b1;
        for (int p = 0; p < 6; p++) begin
            tick();
            chk($sformatf("t2_grant%0d", p), 32'(if0.grant_idx_o), 32'(p % 5));
            ticks(5);
            chk($sformatf("t2_rel%0d", p), 32'(if0.grant_valid_o), 32'd0);
        end

        // 3: mask / priority
        do_reset();
        req = 5'b10110; mask = 5'b00010; prio = 5'b10000;
        tick();
        chk("t3_prio", 32'(if0.grant_idx_o), 32'd4);
        mask = 5'b10100; prio = 5'b00100;
        tick();
        chk("t3_frozen", 32'(if0.grant_idx_o), 32'd4);
        chk("t3_frozen_vec", 32'(if0.grant_vec_o), 32'b10000);
        valid = 1'b1; ready = 1'b1;
        ticks(5);
        chk_u0_idle("t3_rel");
        valid = 1'b0; ready = 1'b0; mask = 5'b00010; prio = '0;
        tick();
        chk("t3_rr", 32'(if0.grant_idx_o), 32'd2);

        // 4: tail release (u1)
        do_reset();
        req = 5'b00001;
        tick();
        chk("t4_u1_g0", 32'(if1.grant_idx_o), 32'd0);
        req = '0; tail = 1'b1; valid = 1'b1; ready = 1'b1;
        tick();
        chk("t4_single_idx", 32'(if1.grant_idx_o), 32'd7);
        chk("t4_single_valid", 32'(if1.grant_valid_o), 32'd0);
        tail = 1'b0; valid = 1'b0; ready = 1'b0; req = 5'b01000;
        tick();
        chk("t4_u1_g3", 32'(if1.grant_idx_o), 32'd3);
        valid = 1'b1; ready = 1'b1;
        ticks(8);
        chk("t4_after8", 32'(if1.grant_valid_o), 32'd1);
        ready = 1'b0; tail = 1'b1;
        ticks(20);
        chk("t4_nowd_valid", 32'(if1.grant_valid_o), 32'd1);
        chk("t4_nowd_to", 32'(if1.timeout_o), 32'd0);
        ready = 1'b1;
        tick();
        chk("t4_ninth_idx", 32'(if1.grant_idx_o), 32'd7);
        chk("t4_ninth_valid", 32'(if1.grant_valid_o), 32'd0);
        valid = 1'b0; ready = 1'b0; tail = 1'b0;

        // 5: watchdog (u0, TIMEOUT=4)
        do_reset();
        req = 5'b00001;
        tick();
        chk("t5_grant", 32'(if0.grant_idx_o), 32'd0);
        req = '0; valid = 1'b1; ready = 1'b0;
        ticks(3);
        chk("t5_stall3_valid", 32'(if0.grant_valid_o), 32'd1);
        chk("t5_stall3_to", 32'(if0.timeout_o), 32'd0);
        tick();
        chk("t5_to_pulse", 32'(if0.timeout_o), 32'd1);
        chk_u0_idle("t5_to");
        tick();
        chk("t5_to_end", 32'(if0.timeout_o), 32'd0);
        req = 5'b00010;
        tick();
        chk("t5_grant1", 32'(if0.grant_idx_o), 32'd1);
        req = '0;
        ticks(2);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        ticks(3);
        chk("t5_reset_stall", 32'(if0.grant_valid_o), 32'd1);
        chk("t5_reset_stall_to", 32'(if0.timeout_o), 32'd0);
        tick();
        chk("t5_to2", 32'(if0.timeout_o), 32'd1);
        valid = 1'b0;

        // 6: reset mid-packet
        do_reset();
        req = 5'b00100;
        tick();
        chk("t6_grant", 32'(if0.grant_idx_o), 32'd2);
        req = '0; valid = 1'b1; ready = 1'b1;
        ticks(2);
        rst = 1'b1;
        tick();
        chk_u0_idle("t6_rst");
        rst = 1'b0; valid = 1'b0; ready = 1'b0; req = 5'b11111;
        tick();
        chk("t6_ptr0", 32'(if0.grant_idx_o), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
